// File: rtl/tmip_out_collector.sv
// tmip_out_collector: collects TMIP's serial result bits into words.
// The stream is MSB-first. Each completed word is queued in a small FIFO
// and offered downstream on a valid/ready port. The last word of each
// frame is tagged, and mid-word gaps and FIFO overflows are flagged.
// Ports:
//   clk, rst_n              clock, async active-high reset
//   cfg_valid, cfg_len      arm strobe and frame word count (0 = 256)
//   out_valid, out_value    TMIP serial bit stream
//   word_valid/data/last    FIFO head; word_ready pops the head
//   frame_done              pulse after the frame's last word is popped
//   err_gap, err_ovf        sticky protocol error flags
//   busy                    high from arm until frame_done
module tmip_out_collector #(
    parameter int WORD_W     = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              out_valid,
    input  logic              out_value,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    input  logic              word_ready,
    output logic              frame_done,
    output logic              err_gap,
    output logic              err_ovf,
    output logic              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0]    BIT_LAST = BW'(WORD_W - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(256);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COLLECT,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    // The final bit of a word comes straight from out_value, so only
    // WORD_W-1 earlier bits need storage.
    logic [WORD_W-2:0] shift_q, shift_d;
    logic              gap_q, gap_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ldrop_q, ldrop_d;

    logic [WORD_W:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;

    logic [WORD_W-1:0] shift_nxt;
    logic              push, push_last, wr, pop, full;

    assign shift_nxt  = {shift_q, out_value};
    assign word_valid = (cnt_q != '0);
    assign {word_last, word_data} = mem_q[rptr_q];
    assign pop        = word_valid & word_ready;
    assign full       = (cnt_q == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so push+pop at full is legal.
    assign wr         = push & (~full | pop);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        gap_d      = gap_q;
        ovf_d      = ovf_q;
        ldrop_d    = ldrop_q;
        done_d     = 1'b0;
        push       = 1'b0;
        push_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d    = ARMED;
                    len_d      = (cfg_len == '0) ? LEN_MAX : cfg_len;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    gap_d      = 1'b0;
                    ovf_d      = 1'b0;
                    ldrop_d    = 1'b0;
                end
            end
            ARMED, COLLECT: begin
                if (out_valid) begin
                    state_d = COLLECT;
                    if (bit_cnt_q == BIT_LAST) begin
                        push       = 1'b1;
                        push_last  = (word_cnt_q == len_q - LEN_W'(1));
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        if (push_last) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        shift_d   = shift_nxt[WORD_W-2:0];
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (bit_cnt_q != '0) begin
                    gap_d     = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            DRAIN: begin
                // A dropped last word leaves no tag, so finish on empty.
                if (pop && word_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (ldrop_q && cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push && !wr) begin
            ovf_d = 1'b1;
            if (push_last) begin
                ldrop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            gap_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ldrop_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            gap_q      <= gap_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            ldrop_q    <= ldrop_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) begin
                mem_q[wptr_q] <= {push_last, shift_nxt};
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end

    assign frame_done = done_q;
    assign err_gap    = gap_q;
    assign err_ovf    = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tmip_out_collector.sv
// tb_tmip_out_collector: directed bench for tmip_out_collector.
// Uses a table of frame scenarios plus hand-written corner sequences.
module tb_tmip_out_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [8:0]  cfg_len = '0;
    logic        out_valid = 1'b0;
    logic        out_value = 1'b0;
    logic        word_valid;
    logic [19:0] word_data;
    logic        word_last;
    logic        word_ready = 1'b0;
    logic        frame_done;
    logic        err_gap;
    logic        err_ovf;
    logic        busy;

    always #5 clk = ~clk;

    tmip_out_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_len    (cfg_len),
        .out_valid  (out_valid),
        .out_value  (out_value),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .frame_done (frame_done),
        .err_gap    (err_gap),
        .err_ovf    (err_ovf),
        .busy       (busy)
    );

    typedef struct {
        int len;
        int gap;
        bit toggle;
        bit poke;
        int exp_n;
        bit exp_gap;
        bit exp_ovf;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    bit          rdy_tog = 1'b0;
    logic [20:0] popq[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            if (word_valid && word_ready) popq.push_back({word_last, word_data});
            if (frame_done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_tog) word_ready = ~word_ready;
    endtask

    task automatic idle(input int n);
        out_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic sbit(input logic b);
        out_valid = 1'b1;
        out_value = b;
        tick();
    endtask

    task automatic send_word(input logic [19:0] w);
        for (int i = 19; i >= 0; i--) sbit(w[i]);
    endtask

    task automatic arm(input int len);
        out_valid = 1'b0;
        cfg_valid = 1'b1;
        cfg_len   = 9'(len);
        popq.delete();
        done_base = done_cnt;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == done_base && t < budget) begin
            tick();
            t++;
        end
        chk("frame_done_seen", done_cnt - done_base, 1);
        tick();
        tick();
    endtask

    task automatic chk_q(input string nm, input logic [20:0] exp[$]);
        chk({nm, "_count"}, popq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < popq.size(); i++)
            chk(nm, popq[i], exp[i]);
    endtask

    function automatic logic [19:0] gen(input int r, input int k);
        return 20'(r * 131 + k * 40503 + 7);
    endfunction

    vec_t        vecs[3];
    logic [20:0] e[$];
    logic [19:0] w;

    initial begin
        vecs[0] = '{len: 16, gap: 3, toggle: 0, poke: 1, exp_n: 16, exp_gap: 0, exp_ovf: 0};
        vecs[1] = '{len: 0,  gap: 0, toggle: 1, poke: 0, exp_n: 256, exp_gap: 0, exp_ovf: 0};
        vecs[2] = '{len: 5,  gap: 1, toggle: 1, poke: 0, exp_n: 5, exp_gap: 0, exp_ovf: 0};

        #2;
        chk("rst_word_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_gap, err_ovf, frame_done}, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();

        // Basic frame: two words back to back, latency and frame_done timing.
        word_ready = 1'b1;
        arm(2);
        chk("basic_busy", busy, 1);
        w = 20'h00001;
        for (int i = 19; i >= 1; i--) sbit(w[i]);
        chk("basic_lat_pre", word_valid, 0);
        sbit(w[0]);
        chk("basic_lat_valid", word_valid, 1);
        chk("basic_w1_data", word_data, 20'h00001);
        chk("basic_w1_last", word_last, 0);
        send_word(20'hABCDE);
        out_valid = 1'b0;
        chk("basic_w2_data", word_data, 20'hABCDE);
        chk("basic_w2_last", word_last, 1);
        chk("basic_done_early", frame_done, 0);
        chk("basic_busy_hold", busy, 1);
        tick();
        chk("basic_done", frame_done, 1);
        chk("basic_busy_fall", busy, 0);
        chk("basic_empty", word_valid, 0);
        tick();
        chk("basic_done_pulse", frame_done, 0);
        e = '{21'h000001, 21'h1ABCDE};
        chk_q("basic_words", e);

        // Mid-word gap: partial word discarded, collection continues.
        arm(1);
        for (int i = 0; i < 7; i++) sbit(1'b1);
        idle(1);
        chk("gap_err", err_gap, 1);
        chk("gap_busy", busy, 1);
        chk("gap_no_word", word_valid, 0);
        send_word(20'hFFFFF);
        out_valid = 1'b0;
        wait_done(50);
        e = '{21'h1FFFFF};
        chk_q("gap_words", e);
        chk("gap_sticky", err_gap, 1);

        // Overflow: six words into a four-deep FIFO with no pops.
        word_ready = 1'b0;
        arm(6);
        chk("ovf_gap_clr", err_gap, 0);
        for (int k = 1; k <= 4; k++) send_word(20'(k));
        chk("ovf_not_yet", err_ovf, 0);
        send_word(20'd5);
        send_word(20'd6);
        out_valid = 1'b0;
        chk("ovf_err", err_ovf, 1);
        chk("ovf_head", word_data, 20'd1);
        word_ready = 1'b1;
        wait_done(50);
        e = '{21'd1, 21'd2, 21'd3, 21'd4};
        chk_q("ovf_words", e);
        chk("ovf_busy", busy, 0);
        chk("ovf_sticky", err_ovf, 1);

        // Push and pop in the same cycle while full: no drop.
        word_ready = 1'b0;
        arm(5);
        chk("fpp_ovf_clr", err_ovf, 0);
        for (int k = 11; k <= 14; k++) send_word(20'(k));
        w = 20'd15;
        for (int i = 19; i >= 1; i--) sbit(w[i]);
        word_ready = 1'b1;
        sbit(w[0]);
        word_ready = 1'b0;
        out_valid = 1'b0;
        chk("fpp_no_ovf", err_ovf, 0);
        chk("fpp_head", word_data, 20'd12);
        word_ready = 1'b1;
        wait_done(50);
        e = '{21'd11, 21'd12, 21'd13, 21'd14, 21'h100000 | 21'd15};
        chk_q("fpp_words", e);

        // Reset in the middle of word 3.
        word_ready = 1'b0;
        arm(3);
        send_word(20'h12345);
        send_word(20'h54321);
        for (int i = 0; i < 10; i++) sbit(1'b1);
        chk("mrst_pre_busy", busy, 1);
        chk("mrst_pre_valid", word_valid, 1);
        rst_n = 1'b1;
        #1;
        chk("mrst_valid", word_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_data", {word_last, word_data}, 0);
        chk("mrst_flags", {err_gap, err_ovf, frame_done}, 0);
        tick();
        rst_n = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 30; i++) sbit(1'b1);
        idle(3);
        chk("idle_busy", busy, 0);
        chk("idle_valid", word_valid, 0);
        chk("idle_gap", err_gap, 0);
        chk("idle_no_done", done_cnt - done_base, 0);

        // Table-driven frames.
        for (int r = 0; r < 3; r++) begin
            word_ready = 1'b1;
            rdy_tog = vecs[r].toggle;
            arm(vecs[r].len);
            e.delete();
            for (int k = 0; k < vecs[r].exp_n; k++)
                e.push_back({(k == vecs[r].exp_n - 1), gen(r, k)});
            for (int k = 0; k < vecs[r].exp_n; k++) begin
                send_word(gen(r, k));
                out_valid = 1'b0;
                if (vecs[r].gap > 0) begin
                    if (vecs[r].poke && k == 0) begin
                        cfg_valid = 1'b1;
                        cfg_len = 9'd1;
                        tick();
                        cfg_valid = 1'b0;
                        idle(vecs[r].gap - 1);
                    end else begin
                        idle(vecs[r].gap);
                    end
                end
            end
            wait_done(300);
            rdy_tog = 1'b0;
            chk_q($sformatf("vec%0d_words", r), e);
            chk($sformatf("vec%0d_gap", r), err_gap, vecs[r].exp_gap);
            chk($sformatf("vec%0d_ovf", r), err_ovf, vecs[r].exp_ovf);
            chk($sformatf("vec%0d_busy", r), busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
